rope_renderer: RTL and testbench

ROPE_RENDERER -- requirements
Module: rope_renderer

---
 rtl/rope_renderer.sv | 94 +++++++++
 tb/tb_rope_renderer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rope_renderer.sv
// rope_renderer: snapshots rope node positions once per frame and draws them as circles over a 3-stage pixel pipeline
module rope_renderer #(
    parameter int N_NODES = 20,
    parameter int COORD_W = 10,
    parameter int RADIUS = 5,
    parameter logic [2:0] BG_COLOR = 3'b010,
    parameter logic [2:0] NODE_COLOR = 3'b101,
    parameter logic [2:0] HEAD_COLOR = 3'b100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       video_on,
    input  logic [COORD_W-1:0]         pix_x,
    input  logic [COORD_W-1:0]         pix_y,
    input  logic                       frame_start,
    input  logic [N_NODES*COORD_W-1:0] nodes_x,
    input  logic [N_NODES*COORD_W-1:0] nodes_y,
    input  logic                       nodes_valid,
    input  logic [1:0]                 mode,
    output logic [2:0]                 graph_rgb,
    output logic                       snap_stale
);
    localparam int D2W = 2 * COORD_W + 1;
    localparam logic [D2W-1:0] R_OUT = D2W'(RADIUS * RADIUS);
    localparam logic [D2W-1:0] R_IN = D2W'((RADIUS - 1) * (RADIUS - 1));

    logic [N_NODES*COORD_W-1:0]        sh_x, sh_y;
    logic [1:0]                        sh_mode, m1, m2;
    logic                              snap_ok, ok1, ok2, v1, v2;
    logic [N_NODES-1:0][COORD_W-1:0]   dx, dy;
    logic [N_NODES-1:0][D2W-1:0]       d2;
    logic [N_NODES-1:0]                hit;
    logic [2:0]                        rgb_n;

    function automatic logic [COORD_W-1:0] absd(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_x <= '0;
            sh_y <= '0;
            sh_mode <= '0;
            snap_ok <= 1'b0;
            snap_stale <= 1'b0;
        end else if (frame_start) begin
            if (nodes_valid) begin
                sh_x <= nodes_x;
                sh_y <= nodes_y;
                sh_mode <= mode;
                snap_ok <= 1'b1;
                snap_stale <= 1'b0;
            end else begin
                snap_stale <= 1'b1;
            end
        end
    end

    // mode and snap_ok travel with each pixel so a snapshot never alters pixels already in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx <= '0;
            dy <= '0;
            d2 <= '0;
            {v1, v2, ok1, ok2} <= '0;
            m1 <= '0;
            m2 <= '0;
            graph_rgb <= '0;
        end else begin
            for (int i = 0; i < N_NODES; i++) begin
                dx[i] <= absd(sh_x[i*COORD_W +: COORD_W], pix_x);
                dy[i] <= absd(sh_y[i*COORD_W +: COORD_W], pix_y);
                d2[i] <= D2W'(dx[i]) * D2W'(dx[i]) + D2W'(dy[i]) * D2W'(dy[i]);
            end
            v1 <= video_on;
            ok1 <= snap_ok;
            m1 <= sh_mode;
            v2 <= v1;
            ok2 <= ok1;
            m2 <= m1;
            graph_rgb <= rgb_n;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_NODES; i++)
            hit[i] = (d2[i] <= R_OUT) && (m2 != 2'd2 || d2[i] > R_IN);
        rgb_n = !v2 ? 3'b000 :
                (!ok2 || m2 == 2'd3) ? BG_COLOR :
                (m2 == 2'd1 && hit[0]) ? HEAD_COLOR :
                (|hit) ? NODE_COLOR : BG_COLOR;
    end
endmodule

// File: tb/tb_rope_renderer.sv
// tb_rope_renderer: directed and randomized checks of rope_renderer against a distance-based colour model
module tb_rope_renderer;
    localparam int N = 20, W = 10, R = 5;
    localparam logic [2:0] BG = 3'b010, NODE = 3'b101, HEAD = 3'b100;

    logic clk = 0, reset = 0, video_on = 0, frame_start = 0, nodes_valid = 0;
    logic [W-1:0] pix_x = '0, pix_y = '0;
    logic [N*W-1:0] nodes_x = '0, nodes_y = '0;
    logic [1:0] mode = '0;
    logic [2:0] graph_rgb;
    logic snap_stale;

    rope_renderer dut (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .nodes_x(nodes_x), .nodes_y(nodes_y),
        .nodes_valid(nodes_valid), .mode(mode), .graph_rgb(graph_rgb), .snap_stale(snap_stale)
    );

    always #5 clk = ~clk;

    int mx[N], my[N];
    int mmode;
    bit mok, mstale;
    logic [2:0] expq[$];
    string tagq[$];
    int n_pass = 0, n_total = 0;

    function automatic logic [2:0] ref_color(int px, int py, bit vid);
        bit any = 0, h0 = 0, h;
        int d2;
        if (!vid) return 3'b000;
        if (!mok || mmode == 3) return BG;
        for (int i = 0; i < N; i++) begin
            d2 = (mx[i] - px) * (mx[i] - px) + (my[i] - py) * (my[i] - py);
            h = d2 <= R * R && (mmode != 2 || d2 > (R - 1) * (R - 1));
            any |= h;
            if (i == 0) h0 = h;
        end
        if (mmode == 1 && h0) return HEAD;
        return any ? NODE : BG;
    endfunction

    task automatic check(string tag, logic [2:0] got, logic [2:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, got, exp);
    endtask

    task automatic set_node(int i, int x, int y);
        nodes_x[i*W +: W] = W'(x);
        nodes_y[i*W +: W] = W'(y);
    endtask

    task automatic set_all(int x, int y);
        for (int i = 0; i < N; i++) set_node(i, x, y);
    endtask

    task automatic step(int px, int py, bit vid, string tag, bit fs = 0, bit nv = 1);
        @(negedge clk);
        reset = 0;
        pix_x = W'(px);
        pix_y = W'(py);
        video_on = vid;
        frame_start = fs;
        nodes_valid = nv;
        expq.push_back(ref_color(px, py, vid));
        tagq.push_back(tag);
        if (fs) begin
            if (nv) begin
                for (int i = 0; i < N; i++) begin
                    mx[i] = int'(nodes_x[i*W +: W]);
                    my[i] = int'(nodes_y[i*W +: W]);
                end
                mmode = int'(mode);
                mok = 1;
                mstale = 0;
            end else mstale = 1;
        end
        @(posedge clk);
        #1;
        check("snap_stale", {2'b0, snap_stale}, {2'b0, mstale});
        if (expq.size() == 3) check(tagq.pop_front(), graph_rgb, expq.pop_front());
    endtask

    task automatic snap(bit nv = 1);
        step(0, 0, 0, "snap", 1, nv);
    endtask

    task automatic flush();
        step(0, 0, 0, "flush");
        step(0, 0, 0, "flush");
    endtask

    task automatic do_reset();
        reset = 1;
        video_on = 0;
        frame_start = 0;
        #1;
        check("reset_rgb", graph_rgb, 3'b000);
        check("reset_stale", {2'b0, snap_stale}, 3'b000);
        expq.delete();
        tagq.delete();
        repeat (2) begin
            expq.push_back(3'b000);
            tagq.push_back("refill");
        end
        mok = 0;
        mstale = 0;
        mmode = 0;
        for (int i = 0; i < N; i++) begin
            mx[i] = 0;
            my[i] = 0;
        end
    endtask

    initial begin
        #1;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_rgb", graph_rgb, 3'b000);
        // visible pixels before any snapshot
        step(0, 0, 1, "pre_snap");
        step(5, 5, 1, "pre_snap");
        step(300, 200, 1, "pre_snap");
        flush();
        // single node, filled
        set_all(600, 400);
        set_node(0, 100, 100);
        mode = 2'd0;
        snap();
        step(103, 104, 1, "d2_25_node");
        step(104, 104, 1, "d2_32_bg");
        step(100, 100, 1, "centre");
        flush();
        // head highlight and outline
        set_all(600, 400);
        set_node(0, 50, 50);
        set_node(1, 52, 50);
        mode = 2'd1;
        snap();
        step(51, 50, 1, "head");
        step(56, 50, 1, "body_mode1");
        mode = 2'd2;
        snap();
        step(50, 50, 1, "outline_centre");
        step(55, 50, 1, "outline_rim");
        mode = 2'd3;
        snap();
        step(50, 50, 1, "mode_off");
        flush();
        // screen edges do not wrap
        set_all(600, 400);
        set_node(0, 2, 2);
        mode = 2'd0;
        snap();
        step(1020, 2, 1, "no_wrap");
        step(0, 0, 1, "corner_d2_8");
        step(1023, 1023, 1, "far_corner");
        flush();
        // shadow copy isolation and stale snapshots
        set_all(600, 400);
        set_node(0, 100, 100);
        snap();
        step(100, 100, 1, "old_img");
        set_node(0, 300, 100);
        mode = 2'd3;
        step(100, 100, 1, "live_bus_ignored");
        step(300, 100, 1, "live_bus_ignored");
        snap(0);
        step(100, 100, 1, "stale_keeps_old");
        step(300, 100, 1, "stale_keeps_old");
        mode = 2'd0;
        snap();
        step(300, 100, 1, "new_img");
        step(100, 100, 1, "new_img_old_gone");
        // snapshot taken mid-stream: in-flight pixels keep the old image
        step(300, 100, 1, "inflight");
        set_node(0, 100, 100);
        step(300, 100, 1, "inflight_fs", 1, 1);
        step(300, 100, 1, "after_fs");
        step(100, 100, 1, "after_fs");
        // blanking alignment
        step(100, 100, 0, "blank_on_node");
        step(100, 100, 1, "vid_toggle");
        step(100, 100, 0, "vid_toggle");
        step(100, 100, 0, "vid_toggle");
        step(100, 100, 1, "vid_toggle");
        step(400, 400, 1, "vid_toggle");
        // reset mid-line with a full pipeline
        step(100, 100, 1, "pre_reset");
        step(101, 100, 1, "pre_reset");
        do_reset();
        step(100, 100, 1, "post_reset_bg");
        step(100, 100, 1, "post_reset_bg");
        step(100, 100, 1, "post_reset_bg");
        step(100, 100, 1, "post_reset_bg");
        snap();
        step(100, 100, 1, "post_reset_snap");
        flush();
        // randomized frames
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < N; i++) set_node(i, int'($urandom_range(1023)), int'($urandom_range(1023)));
            mode = 2'($urandom_range(3));
            snap(bit'($urandom_range(3) != 0));
            for (int p = 0; p < 40; p++) begin
                int k;
                k = int'($urandom_range(N - 1));
                step((int'(nodes_x[k*W +: W]) + int'($urandom_range(14)) - 7 + 1024) % 1024,
                     (int'(nodes_y[k*W +: W]) + int'($urandom_range(14)) - 7 + 1024) % 1024,
                     bit'($urandom_range(7) != 0), "random", bit'($urandom_range(15) == 0),
                     bit'($urandom_range(1)));
            end
        end
        flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
